// File: rtl/apmu_ibex_rf_wb_queue.sv
// Register-file writeback arbiter: ALU writes win, LSU loads queue behind them.
// Optional operand forwarding of pending writes is enabled by APMU_RF_WBQ_BYPASS_EN.
module apmu_ibex_rf_wb_queue #(
   parameter int DataWidth = 32,
   parameter int Depth     = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 alu_we_i,
   input  logic [4:0]           alu_waddr_i,
   input  logic [DataWidth-1:0] alu_wdata_i,
   input  logic                 lsu_valid_i,
   output logic                 lsu_ready_o,
   input  logic [4:0]           lsu_waddr_i,
   input  logic [DataWidth-1:0] lsu_wdata_i,
   output logic                 rf_we_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   input  logic [4:0]           raddr_a_i,
   input  logic [4:0]           raddr_b_i,
   output logic                 fwd_a_valid_o,
   output logic                 fwd_b_valid_o,
   output logic [DataWidth-1:0] fwd_a_data_o,
   output logic [DataWidth-1:0] fwd_b_data_o,
   output logic                 idle_o
);
   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;

   logic [Depth-1:0]     ent_valid_reg;
   logic [4:0]           ent_addr_reg [Depth];
   logic [DataWidth-1:0] ent_data_reg [Depth];
   logic [PtrW-1:0]      head_reg;
   logic [PtrW-1:0]      tail_reg;
   logic [CntW-1:0]      count_reg;

   logic queue_empty;
   logic alu_fire;
   logic lsu_fire;
   logic lsu_write;
   logic do_pop;
   logic do_push;

   assign queue_empty = (count_reg == '0);
   assign lsu_ready_o = (count_reg != CntW'(Depth));
   assign alu_fire    = alu_we_i && (alu_waddr_i != 5'd0);
   assign lsu_fire    = lsu_valid_i && lsu_ready_o;
   // A same-address ALU write is younger, so the load is accepted but discarded.
   assign lsu_write   = lsu_fire && (lsu_waddr_i != 5'd0) &&
                        !(alu_fire && (alu_waddr_i == lsu_waddr_i));
   assign do_pop      = !alu_fire && !queue_empty;
   assign do_push     = lsu_write && (alu_fire || !queue_empty);
   assign idle_o      = queue_empty && !rf_we_o;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ent_valid_reg <= '0;
         head_reg      <= '0;
         tail_reg      <= '0;
         count_reg     <= '0;
         rf_we_o       <= 1'b0;
         rf_waddr_o    <= 5'd0;
         rf_wdata_o    <= '0;
      end else begin
         for (int i = 0; i < Depth; i++) begin
            if (alu_fire && (ent_addr_reg[i] == alu_waddr_i)) begin
               ent_valid_reg[i] <= 1'b0;
            end
         end
         if (do_pop) begin
            ent_valid_reg[head_reg] <= 1'b0;
            head_reg                <= head_reg + 1'b1;
         end
         if (do_push) begin
            ent_valid_reg[tail_reg] <= 1'b1;
            tail_reg                <= tail_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase

         if (alu_fire) begin
            rf_we_o    <= 1'b1;
            rf_waddr_o <= alu_waddr_i;
            rf_wdata_o <= alu_wdata_i;
         end else if (!queue_empty) begin
            // A squashed head still consumes a slot, with the write suppressed.
            rf_we_o    <= ent_valid_reg[head_reg];
            rf_waddr_o <= ent_addr_reg[head_reg];
            rf_wdata_o <= ent_data_reg[head_reg];
         end else if (lsu_write) begin
            rf_we_o    <= 1'b1;
            rf_waddr_o <= lsu_waddr_i;
            rf_wdata_o <= lsu_wdata_i;
         end else begin
            rf_we_o    <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni && do_push) begin
         ent_addr_reg[tail_reg] <= lsu_waddr_i;
         ent_data_reg[tail_reg] <= lsu_wdata_i;
      end
   end

`ifdef APMU_RF_WBQ_BYPASS_EN
   // Walk oldest to youngest so the youngest match wins; the output register is the fallback.
   function automatic logic [DataWidth:0] fwd_lookup(input logic [4:0] raddr);
      logic [DataWidth:0] res;
      logic [PtrW-1:0]    idx;
      res = '0;
      if (rf_we_o && (rf_waddr_o == raddr)) begin
         res = {1'b1, rf_wdata_o};
      end
      for (int i = 0; i < Depth; i++) begin
         idx = head_reg + PtrW'(i);
         if ((CntW'(i) < count_reg) && ent_valid_reg[idx] && (ent_addr_reg[idx] == raddr)) begin
            res = {1'b1, ent_data_reg[idx]};
         end
      end
      if (raddr == 5'd0) begin
         res = '0;
      end
      return res;
   endfunction

   always_comb begin
      {fwd_a_valid_o, fwd_a_data_o} = fwd_lookup(raddr_a_i);
      {fwd_b_valid_o, fwd_b_data_o} = fwd_lookup(raddr_b_i);
   end
`else
   logic unused_raddr;
   assign unused_raddr  = ^{raddr_a_i, raddr_b_i};
   assign fwd_a_valid_o = 1'b0;
   assign fwd_b_valid_o = 1'b0;
   assign fwd_a_data_o  = '0;
   assign fwd_b_data_o  = '0;
`endif

endmodule

// File: tb/tb_apmu_ibex_rf_wb_queue.sv
// Self-checking bench for apmu_ibex_rf_wb_queue: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_apmu_ibex_rf_wb_queue;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic          alu_we_i;
   logic [4:0]    alu_waddr_i;
   logic [DW-1:0] alu_wdata_i;
   logic          lsu_valid_i;
   logic          lsu_ready_o;
   logic [4:0]    lsu_waddr_i;
   logic [DW-1:0] lsu_wdata_i;
   logic          rf_we_o;
   logic [4:0]    rf_waddr_o;
   logic [DW-1:0] rf_wdata_o;
   logic [4:0]    raddr_a_i;
   logic [4:0]    raddr_b_i;
   logic          fwd_a_valid_o;
   logic          fwd_b_valid_o;
   logic [DW-1:0] fwd_a_data_o;
   logic [DW-1:0] fwd_b_data_o;
   logic          idle_o;

   always #5 clk = ~clk;

   apmu_ibex_rf_wb_queue #(.DataWidth(DW), .Depth(DEPTH)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .alu_we_i(alu_we_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
      .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
      .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
      .fwd_a_valid_o(fwd_a_valid_o), .fwd_b_valid_o(fwd_b_valid_o),
      .fwd_a_data_o(fwd_a_data_o), .fwd_b_data_o(fwd_b_data_o),
      .idle_o(idle_o)
   );

   typedef struct {
      logic          valid;
      logic [4:0]    addr;
      logic [DW-1:0] data;
   } ent_t;

   // Reference model: pending loads in age order plus the expected write port.
   ent_t          q[$];
   logic          m_we;
   logic [4:0]    m_waddr;
   logic [DW-1:0] m_wdata;
   logic          m_known;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [DW:0] model_fwd(input logic [4:0] ra);
      logic [DW:0] r;
      r = '0;
`ifdef APMU_RF_WBQ_BYPASS_EN
      if (ra != 5'd0) begin
         if (m_we && m_waddr == ra) r = {1'b1, m_wdata};
         foreach (q[i]) begin
            if (q[i].valid && q[i].addr == ra) r = {1'b1, q[i].data};
         end
      end
`endif
      return r;
   endfunction

   task automatic model_step(input logic rst_n, input logic a_we, input logic [4:0] a_addr,
                             input logic [DW-1:0] a_data, input logic l_v,
                             input logic [4:0] l_addr, input logic [DW-1:0] l_data);
      int   n_before;
      logic alu, lacc;
      ent_t head;
      ent_t ne;
      if (!rst_n) begin
         q.delete();
         m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_known = 1'b1;
         return;
      end
      n_before = q.size();
      alu  = a_we && (a_addr != 0);
      lacc = l_v && (n_before < DEPTH) && (l_addr != 0) && !(alu && l_addr == a_addr);
      head = '{1'b0, 5'd0, '0};
      if (!alu && n_before > 0) head = q.pop_front();
      if (alu) begin
         foreach (q[i]) if (q[i].addr == a_addr) q[i].valid = 1'b0;
      end
      if (lacc && (alu || n_before > 0)) begin
         ne = '{1'b1, l_addr, l_data};
         q.push_back(ne);
      end
      if (alu) begin
         m_we = 1'b1; m_waddr = a_addr; m_wdata = a_data;
      end else if (n_before > 0) begin
         m_we = head.valid; m_waddr = head.addr; m_wdata = head.data;
      end else if (lacc) begin
         m_we = 1'b1; m_waddr = l_addr; m_wdata = l_data;
      end else begin
         m_we = 1'b0;
      end
      m_known = m_we;
   endtask

   task automatic check_regs();
      check_eq("rf_we", rf_we_o, m_we);
      if (m_known) begin
         check_eq("rf_waddr", rf_waddr_o, m_waddr);
         check_eq("rf_wdata", rf_wdata_o, m_wdata);
      end
      check_eq("idle", idle_o, (q.size() == 0) && !m_we);
   endtask

   // One clock cycle: drive, check combinational outputs, advance model, check registers.
   task automatic drive(input logic rst_n, input logic a_we, input logic [4:0] a_addr,
                        input logic [DW-1:0] a_data, input logic l_v,
                        input logic [4:0] l_addr, input logic [DW-1:0] l_data,
                        input logic [4:0] ra, input logic [4:0] rb);
      logic [DW:0] fa, fb;
      rst_ni = rst_n; alu_we_i = a_we; alu_waddr_i = a_addr; alu_wdata_i = a_data;
      lsu_valid_i = l_v; lsu_waddr_i = l_addr; lsu_wdata_i = l_data;
      raddr_a_i = ra; raddr_b_i = rb;
      #1;
      check_eq("lsu_ready", lsu_ready_o, q.size() < DEPTH);
      fa = model_fwd(ra);
      fb = model_fwd(rb);
      check_eq("fwd_a_valid", fwd_a_valid_o, fa[DW]);
      check_eq("fwd_a_data", fwd_a_data_o, fa[DW-1:0]);
      check_eq("fwd_b_valid", fwd_b_valid_o, fb[DW]);
      check_eq("fwd_b_data", fwd_b_data_o, fb[DW-1:0]);
      model_step(rst_n, a_we, a_addr, a_data, l_v, l_addr, l_data);
      @(posedge clk);
      #1;
      cyc++;
      check_regs();
      $display("cyc %0d rst_n=%0b alu=%0b x%0d lsu=%0b x%0d -> we=%0b x%0d 0x%0h q=%0d",
               cyc, rst_n, a_we, a_addr, l_v, l_addr, rf_we_o, rf_waddr_o, rf_wdata_o, q.size());
   endtask

   task automatic idle_cycle();
      drive(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
   endtask

   initial begin
      rst_ni = 1'b0; alu_we_i = 1'b0; alu_waddr_i = '0; alu_wdata_i = '0;
      lsu_valid_i = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0;
      raddr_a_i = '0; raddr_b_i = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      model_step(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      check_regs();
      check_eq("reset_waddr", rf_waddr_o, 0);
      check_eq("reset_ready", lsu_ready_o, 1);

      // Lone load into an empty queue goes straight to the write port.
      drive(1'b1, 1'b0, 5'd0, '0, 1'b1, 5'd5, 32'hA5, 5'd5, 5'd0);
      check_eq("t026_we", rf_we_o, 1);
      check_eq("t026_waddr", rf_waddr_o, 5);
      check_eq("t026_wdata", rf_wdata_o, 32'hA5);
      idle_cycle();
      check_eq("t026_idle", idle_o, 1);

      // ALU and LSU collide on different registers.
      drive(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd4, 5'd3);
      check_eq("t027_a_waddr", rf_waddr_o, 3);
      check_eq("t027_a_wdata", rf_wdata_o, 32'h11);
      idle_cycle();
      check_eq("t027_b_we", rf_we_o, 1);
      check_eq("t027_b_waddr", rf_waddr_o, 4);
      check_eq("t027_b_wdata", rf_wdata_o, 32'h22);
      idle_cycle();

      // Queued load squashed by a later ALU write to the same register.
      drive(1'b1, 1'b1, 5'd1, 32'h5, 1'b1, 5'd7, 32'h1, 5'd7, 5'd1);
      drive(1'b1, 1'b1, 5'd7, 32'h2, 1'b0, 5'd0, '0, 5'd7, 5'd0);
      check_eq("t028_alu_waddr", rf_waddr_o, 7);
      check_eq("t028_alu_wdata", rf_wdata_o, 32'h2);
      idle_cycle();
      check_eq("t028_drain_we", rf_we_o, 0);
      idle_cycle();

      // Fill the queue while the ALU keeps the port busy, then drain.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 1'b1, 5'(10 + i), 32'(i), 1'b1, 5'(20 + i), 32'(100 + i), 5'(20 + i), 5'd0);
      end
      check_eq("t029_full_ready", lsu_ready_o, 0);
      for (int i = 0; i < DEPTH; i++) begin
         idle_cycle();
         check_eq("t029_drain_waddr", rf_waddr_o, 20 + i);
         check_eq("t029_drain_wdata", rf_wdata_o, 100 + i);
         if (i == 0) check_eq("t029_ready_back", lsu_ready_o, 1);
      end
      idle_cycle();

      // Two pending writes to x9: forwarding returns the younger.
      drive(1'b1, 1'b1, 5'd1, 32'h3, 1'b1, 5'd9, 32'h10, 5'd9, 5'd0);
      drive(1'b1, 1'b1, 5'd2, 32'h4, 1'b1, 5'd9, 32'h20, 5'd9, 5'd0);
      raddr_a_i = 5'd9;
      #1;
`ifdef APMU_RF_WBQ_BYPASS_EN
      check_eq("t030_fwd_valid", fwd_a_valid_o, 1);
      check_eq("t030_fwd_data", fwd_a_data_o, 32'h20);
`else
      check_eq("t030_fwd_valid", fwd_a_valid_o, 0);
      check_eq("t030_fwd_data", fwd_a_data_o, 0);
`endif
      repeat (3) idle_cycle();

      // Reset while entries are pending discards them.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 5'(1 + i), 32'(i), 1'b1, 5'(12 + i), 32'(200 + i), 5'd0, 5'd0);
      end
      drive(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88, 5'd12, 5'd13);
      check_eq("t031_ready", lsu_ready_o, 1);
      check_eq("t031_idle", idle_o, 1);
      check_eq("t031_we", rf_we_o, 0);
      idle_cycle();
      check_eq("t031_no_write", rf_we_o, 0);

      // Random traffic with a small address pool to provoke collisions.
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               $urandom, ($urandom_range(0, 4) < 3), 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      repeat (DEPTH + 2) idle_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/apmu_ibex_rf_wb_queue.md
APMU_IBEX_RF_WB_QUEUE -- requirements
Module: apmu_ibex_rf_wb_queue

Interface
REQ-001 SHALL have parameter DataWidth, default 32, register data width.
REQ-002 SHALL have parameter Depth, default 4, LSU queue entries; power of two, at least 2.
REQ-003 SHALL have ports: clk_i  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have ports: rst_ni  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports: alu_we_i in 1 / alu_waddr_i in 5 / alu_wdata_i in DataWidth  ALU writeback, never stalled.
REQ-006 SHALL have ports: lsu_valid_i in 1 / lsu_ready_o out 1 / lsu_waddr_i in 5 / lsu_wdata_i in DataWidth  load writeback, valid/ready handshake.
REQ-007 SHALL have ports: rf_we_o out 1 / rf_waddr_o out 5 / rf_wdata_o out DataWidth  registered write port into the register file.
REQ-008 SHALL have ports: raddr_a_i, raddr_b_i in 5; fwd_a_valid_o, fwd_b_valid_o out 1; fwd_a_data_o, fwd_b_data_o out DataWidth  operand forwarding of pending writes.
REQ-009 SHALL have port idle_o out 1: queue empty and rf_we_o low.

Function
REQ-010 SHALL drop writes to address 0 at input: no enqueue, no rf_we_o; LSU handshake still completes.
REQ-011 SHALL define LSU fire as lsu_valid_i and lsu_ready_o; lsu_ready_o = queue not full, from registered count only.
REQ-012 SHALL load the output register each cycle with priority: (1) valid ALU write; (2) queue head pop; (3) LSU fire with queue empty; else rf_we_o=0 next cycle.
REQ-013 SHALL enqueue an LSU fire at tail when an ALU write occurs the same cycle or queue is non-empty; order among LSU writes preserved.
REQ-014 SHALL present every accepted write on rf_* exactly one cycle after it wins arbitration.
REQ-015 SHALL, on a valid ALU write, clear the valid bit of every queue entry with equal address (squash; ALU is younger).
REQ-016 SHALL treat same-cycle ALU and LSU fire to equal address as ALU younger: LSU write accepted and discarded.
REQ-017 SHALL pop a squashed head entry as a normal drain slot producing rf_we_o=0 next cycle.
REQ-018 SHALL support simultaneous push and pop; count unchanged; pointers wrap modulo Depth.
REQ-019 SHALL drive fwd_x_valid_o/fwd_x_data_o combinationally: youngest valid queue entry matching raddr_x_i, else output register when rf_we_o and rf_waddr_o match, else valid 0, data 0.
REQ-020 SHALL never forward for raddr_x_i = 0.

Reset
REQ-021 SHALL, while rst_ni low at a clock edge, clear count, pointers, all entry valid bits, rf_we_o, rf_waddr_o, rf_wdata_o to 0.
REQ-022 SHALL discard in-flight queued writes on reset mid-operation; after reset lsu_ready_o=1, idle_o=1, fwd_* = 0.
REQ-023 SHALL ignore all inputs during the reset cycle.

Configuration
REQ-024 SHALL honour macro APMU_RF_WBQ_BYPASS_EN: defined -> forwarding per REQ-019/020.
REQ-025 SHALL, without APMU_RF_WBQ_BYPASS_EN, tie fwd_*_valid_o and fwd_*_data_o to 0 with no compare logic; all other behaviour identical.

Verification
REQ-026 SHALL cover: LSU write x5=0xA5 alone, queue empty -> rf_we_o=1, waddr 5, wdata 0xA5 next cycle; idle_o=1 after.
REQ-027 SHALL cover: ALU x3=0x11 and LSU x4=0x22 same cycle -> x3 at cycle+1, x4 at cycle+2.
REQ-028 SHALL cover: LSU x7=0x1 enqueued behind collision, then ALU x7=0x2 -> entry squashed, only 0x2 written to x7, extra rf_we_o=0 drain slot.
REQ-029 SHALL cover: ALU every cycle, 4 LSU fires (Depth 4) -> lsu_ready_o=0 after 4th; ALU stops -> drain in order, ready returns 1 after first pop.
REQ-030 SHALL cover: queue holds x9=0x10 then x9=0x20, raddr_a_i=9 -> fwd_a_valid_o=1, fwd_a_data_o=0x20; macro undefined -> 0/0.
REQ-031 SHALL cover: reset asserted with 3 entries queued -> no further rf_we_o, lsu_ready_o=1, idle_o=1 first cycle after release.
